// File: rtl/ps2_recv_pkg.sv
// Shared definitions for the PS/2 receiver: frame geometry, FSM state encoding
// and the parity helper.
package ps2_recv_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Odd parity holds when data plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 line conditioning: two-flop synchronizers on clock and data, a
// FILTER_LEN-deep glitch filter on the clock, and filtered falling-edge detect.
module ps2_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_f_o,
    output logic fall_o,
    output logic data_s_o
);

    logic [1:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  clk_f_q;
    logic                  fall_q;

    // Filtered clock only changes once the whole history agrees; fall marks 1->0.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            hist_q      <= '1;
            clk_f_q     <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            hist_q      <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
            fall_q      <= 1'b0;
            if (hist_q == '0) begin
                clk_f_q <= 1'b0;
                fall_q  <= clk_f_q;
            end else if (&hist_q) begin
                clk_f_q <= 1'b1;
            end
        end
    end

    assign clk_f_o  = clk_f_q;
    assign fall_o   = fall_q;
    assign data_s_o = data_sync_q[1];

endmodule

// File: rtl/ps2_recv.sv
// Host-side PS/2 receiver: deserializes 11-bit frames into bytes with rdy/err strobes.
// Optional macro PS2_RECV_TIMEOUT_EN aborts a stalled frame after TIMEOUT_CYCLES clocks.
module ps2_recv
    import ps2_recv_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
`ifdef PS2_RECV_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2500
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       rdy,
    output logic       err,
    output logic       busy
);

    localparam int unsigned CNT_W = 3;

    logic clk_f;
    logic fall;
    logic data_s;
    logic sample;

    ps2_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .clk_f_o    (clk_f),
        .fall_o     (fall),
        .data_s_o   (data_s)
    );

    assign sample = fall & ~clk_f;

    ps2_state_e                state_q;
    logic [CNT_W-1:0]          bitcnt_q;
    logic [PS2_DATA_BITS-1:0]  shreg_q;
    logic                      parity_q;
    logic [7:0]                code_q;
    logic                      rdy_q;
    logic                      err_q;
    logic                      busy_q;
`ifdef PS2_RECV_TIMEOUT_EN
    logic [15:0]               to_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            code_q   <= 8'h00;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef PS2_RECV_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                // A high start bit is silently ignored.
                ST_IDLE: begin
                    if (sample && !data_s) begin
                        state_q  <= ST_DATA;
                        bitcnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        shreg_q  <= {data_s, shreg_q[PS2_DATA_BITS-1:1]};
                        bitcnt_q <= bitcnt_q + CNT_W'(1);
                        if (bitcnt_q == CNT_W'(PS2_DATA_BITS - 1)) begin
                            state_q <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample) begin
                        parity_q <= data_s;
                        state_q  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        if (data_s && odd_parity_ok(shreg_q, parity_q)) begin
                            code_q <= shreg_q;
                            rdy_q  <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
`ifdef PS2_RECV_TIMEOUT_EN
            // Watchdog on the gap between falls; overrides the FSM when it expires.
            if (state_q == ST_IDLE || sample) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                to_cnt_q <= '0;
                state_q  <= ST_IDLE;
                busy_q   <= 1'b0;
                err_q    <= 1'b1;
            end else begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
`endif
        end
    end

    assign code = code_q;
    assign rdy  = rdy_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_ps2_recv.sv
// Self-checking bench for ps2_recv: vector table, hand-written corner sequences
// and randomized frames against a frame-level reference model.
module tb_ps2_recv;

    localparam int TIMEOUT_CYCLES = 2500;
    localparam int HALF           = 100;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       rdy;
    logic       err;
    logic       busy;

    ps2_recv dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .code     (code),
        .rdy      (rdy),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    int pulse_cyc = 0;
    int fall_cyc = 0;
    logic rdy_prev = 1'b0;
    logic err_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rdy) rdy_cnt++;
        if (err) err_cnt++;
        if (rdy || err) pulse_cyc = cyc;
        if (rdy && err) both_cnt++;
        if ((rdy && rdy_prev) || (err && err_prev)) wide_cnt++;
        rdy_prev = rdy;
        err_prev = err;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Device-side bit clocking: data set while clock high, then clock low.
    task automatic send_bits(input logic [10:0] bits, input int n, input int h, input int gb);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = bits[i];
            if (i == gb) begin
                repeat (h / 2) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (3) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (h / 2) @(negedge clk);
            end else begin
                repeat (h) @(negedge clk);
            end
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (h) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic flip, input logic stop);
        logic par;
        par = ~(^d) ^ flip;
        return {stop, par, d, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop, input int h, input int gb);
        send_bits(make_frame(d, flip, stop), 11, h, gb);
        repeat (20) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       flip;
        logic       stop;
        logic       exp_rdy;
        logic       exp_err;
        logic [7:0] exp_code;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int r0, e0, lat, waited, busy_hi;
        logic [7:0] model_code;
        logic [7:0] d;
        logic flip, stop, good;
        logic [10:0] bits;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};
        vecs[1] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01};
        vecs[4] = '{8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 8'h81};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81};

        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_code", 32'(code), 32'h00);
        check("reset_rdy", 32'(rdy), 0);
        check("reset_err", 32'(err), 0);
        check("reset_busy", 32'(busy), 0);

        // Good frames, then parity and stop errors.
        for (int i = 0; i < 7; i++) begin
            r0 = rdy_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].flip, vecs[i].stop, HALF, -1);
            check($sformatf("vec%0d_rdy", i), 32'(rdy_cnt - r0), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_code", i), 32'(code), 32'(vecs[i].exp_code));
            check($sformatf("vec%0d_busy", i), 32'(busy), 0);
            lat = pulse_cyc - fall_cyc;
            check($sformatf("vec%0d_latency", i), 32'(lat >= 10 && lat <= 12), 1);
        end
        model_code = 8'h81;

        // Short low glitch while idle must not start a frame.
        busy_hi = 0;
        @(negedge clk) ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy) busy_hi++;
        end
        check("idle_glitch_busy", 32'(busy_hi), 0);

        // Glitch in the high phase of data bit 3.
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, HALF, 4);
        check("glitch_rdy", 32'(rdy_cnt - r0), 1);
        check("glitch_err", 32'(err_cnt - e0), 0);
        check("glitch_code", 32'(code), 32'h3C);
        model_code = 8'h3C;

        // Truncated frame: start + 3 data bits, then clock held high.
        e0 = err_cnt;
        bits = make_frame(8'hF0, 1'b0, 1'b1);
        send_bits(bits, 4, HALF, -1);
        waited = 0;
`ifdef PS2_RECV_TIMEOUT_EN
        while (err_cnt == e0 && waited < TIMEOUT_CYCLES + 600) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_err", 32'(err_cnt - e0), 1);
        lat = pulse_cyc - fall_cyc;
        check("timeout_delay", 32'(lat >= TIMEOUT_CYCLES && lat <= TIMEOUT_CYCLES + 20), 1);
        repeat (2) @(negedge clk);
        check("timeout_busy", 32'(busy), 0);
`else
        repeat (TIMEOUT_CYCLES + 200) @(negedge clk);
        check("stall_busy", 32'(busy), 1);
        check("stall_err", 32'(err_cnt - e0), 0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        model_code = 8'h00;
`endif
        r0 = rdy_cnt;
        send_frame(8'hF0, 1'b0, 1'b1, HALF, -1);
        check("after_stall_rdy", 32'(rdy_cnt - r0), 1);
        check("after_stall_code", 32'(code), 32'hF0);

        // Reset mid-frame after data bit 4.
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_bits(make_frame(8'hAA, 1'b0, 1'b1), 6, HALF, -1);
        repeat (20) @(negedge clk);
        check("midframe_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_code", 32'(code), 32'h00);
        check("rst_no_pulse", 32'((rdy_cnt - r0) + (err_cnt - e0)), 0);
        send_frame(8'hAA, 1'b0, 1'b1, HALF, -1);
        check("post_rst_rdy", 32'(rdy_cnt - r0), 1);
        check("post_rst_code", 32'(code), 32'hAA);
        model_code = 8'hAA;

        // Randomized frames against the frame-level model.
        for (int i = 0; i < 14; i++) begin
            d    = 8'($urandom_range(0, 255));
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 6) != 0);
            bits = make_frame(d, flip, stop);
            good = (bits[10] == 1'b1) && ((^bits[9:1]) == 1'b1);
            if (good) model_code = d;
            r0 = rdy_cnt;
            e0 = err_cnt;
            send_frame(d, flip, stop, 40, -1);
            check($sformatf("rnd%0d_rdy", i), 32'(rdy_cnt - r0), 32'(good));
            check($sformatf("rnd%0d_err", i), 32'(err_cnt - e0), 32'(!good));
            check($sformatf("rnd%0d_code", i), 32'(code), 32'(model_code));
        end

        check("rdy_err_overlap", 32'(both_cnt), 0);
        check("pulse_width", 32'(wide_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
